timer_scheduler: RTL and testbench

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 178 +++++++++++++++++
 tb/tb_timer_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// timer_scheduler
//   Shares one programmable 75us timer between NUM_REQ requesters.
//   Requests are queued per requester and served in round-robin order.
//   Each served request runs IDLE -> START -> WAIT -> DONE.
//
// Optional feature:
//   TIMER_SCHED_CANCEL_EN adds the `cancel` input. It drops a queued request.
//   It also aborts the running request without a done pulse.
//
// Parameters:
//   NUM_REQ : number of requesters (2..8)
//   LEN_W   : width of a delay length, in timer ticks
//
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-low reset
//   req           : one-cycle request pulse per requester
//   req_length    : per-requester length, slice i = [i*LEN_W +: LEN_W]
//   cancel        : per-requester cancel pulse (only with TIMER_SCHED_CANCEL_EN)
//   timer_start   : one-cycle start pulse to the shared timer
//   timer_length  : length for the timer, valid while timer_start is high
//   timer_expired : one-cycle expiry pulse from the timer
//   done          : one-cycle completion pulse per requester
//   pending       : queued-but-not-started flags
//   busy          : FSM not in IDLE
//   active_id     : requester that owns the timer, valid while busy
//   req_err       : one-cycle pulse, the cycle after a rejected request
//   state_dbg     : current FSM state (0 IDLE, 1 START, 2 WAIT, 3 DONE)
//
// Handshake: every control signal here is a single-cycle pulse.
//   No ready back-pressure exists.
//   A req pulse is either accepted on its edge, or flagged by req_err one
//   cycle later.
module timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_length,
`ifdef TIMER_SCHED_CANCEL_EN
  input  logic [NUM_REQ-1:0]       cancel,
`endif
  output logic                     timer_start,
  output logic [LEN_W-1:0]         timer_length,
  input  logic                     timer_expired,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       pending,
  output logic                     busy,
  output logic [2:0]               active_id,
  output logic [NUM_REQ-1:0]       req_err,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] done_q, err_q;
  logic               ts_q;
  logic [LEN_W-1:0]   tl_q;
  logic [2:0]         active_q, last_q;
  logic [LEN_W-1:0]   len_q [NUM_REQ];

  logic [NUM_REQ-1:0] cancel_w;
  logic [NUM_REQ-1:0] accept, grant_mask;
  logic               running, kill, found;
  logic [2:0]         sel;
  logic [3:0]         cand;
  logic [LEN_W-1:0]   sel_len;

`ifdef TIMER_SCHED_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = '0;
`endif

  always_comb begin
    running = (state_q == S_START) || (state_q == S_WAIT);
    accept  = '0;
    kill    = 1'b0;
    // The owner is blocked only while its run is live.
    // In DONE the owner may re-queue itself.
    for (int i = 0; i < NUM_REQ; i++) begin
      accept[i] = req[i] && !pending_q[i] && !(running && active_q == 3'(i));
      if (running && active_q == 3'(i) && cancel_w[i]) kill = 1'b1;
    end

    // Round-robin: scan from last_q+1 upward, wrapping at NUM_REQ.
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && pending_q[i] && !cancel_w[i] && cand == 4'(i)) begin
          found = 1'b1;
          sel   = 3'(i);
        end
      end
    end

    sel_len    = '0;
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == 3'(i)) begin
        sel_len = len_q[i];
        if (state_q == S_IDLE && found) grant_mask[i] = 1'b1;
      end
    end

    pending_d = (pending_q | accept) & ~cancel_w & ~grant_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
      ts_q      <= 1'b0;
      tl_q      <= '0;
      active_q  <= '0;
      last_q    <= 3'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) len_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= req & ~accept;
      done_q    <= '0;
      ts_q      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) len_q[i] <= req_length[i*LEN_W +: LEN_W];
      end

      case (state_q)
        S_IDLE: begin
          if (found) begin
            active_q <= sel;
            tl_q     <= sel_len;
            ts_q     <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: state_q <= kill ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (kill) begin
            state_q <= S_IDLE;
          end else if (timer_expired) begin
            state_q <= S_DONE;
            for (int i = 0; i < NUM_REQ; i++) done_q[i] <= (active_q == 3'(i));
          end
        end
        S_DONE: begin
          last_q  <= active_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign timer_start  = ts_q;
  assign timer_length = tl_q;
  assign done         = done_q;
  assign pending      = pending_q;
  assign busy         = (state_q != S_IDLE);
  assign active_id    = active_q;
  assign req_err      = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_timer_scheduler.sv
module tb_timer_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 10;
  localparam int W       = 13;  // {id[2:0], len[9:0]}

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_length;
  logic [NUM_REQ-1:0]       cancel;
  logic                     timer_start;
  logic [LEN_W-1:0]         timer_length;
  logic                     timer_expired;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       pending;
  logic                     busy;
  logic [2:0]               active_id;
  logic [NUM_REQ-1:0]       req_err;
  logic [1:0]               state_dbg;

  logic model_exp, man_exp, auto_timer, in_flight;
  assign timer_expired = model_exp | man_exp;

  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_done_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  timer_scheduler #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_length    (req_length),
`ifdef TIMER_SCHED_CANCEL_EN
    .cancel        (cancel),
`endif
    .timer_start   (timer_start),
    .timer_length  (timer_length),
    .timer_expired (timer_expired),
    .done          (done),
    .pending       (pending),
    .busy          (busy),
    .active_id     (active_id),
    .req_err       (req_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_len(input int i, input int v);
    req_length[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic push_run(input int id, input int len, input bit completes);
    exp_q.push_back({3'(id), LEN_W'(len)});
    if (completes) exp_done_q.push_back(3'(id));
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    req     = '0;
    cancel  = '0;
    man_exp = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || pending != '0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 1000), 1);
    repeat (2) @(negedge clk);
    check({tag, "_starts_left"}, exp_q.size(), 0);
    check({tag, "_dones_left"}, exp_done_q.size(), 0);
  endtask

  // ---------------- timer model: expires len+1 cycles after start ----------------
  initial begin : timer_model
    int  remaining;
    bit  armed;
    model_exp = 1'b0;
    armed     = 1'b0;
    remaining = 0;
    forever begin
      @(negedge clk);
      model_exp = 1'b0;
      if (!reset || !auto_timer) begin
        armed = 1'b0;
      end else if (timer_start) begin
        armed     = 1'b1;
        remaining = int'(timer_length);
      end else if (armed) begin
        if (remaining == 0) begin
          model_exp = 1'b1;
          armed     = 1'b0;
        end else begin
          remaining--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] e;
    logic [2:0]   d;
    in_flight = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (timer_start) begin
          check("start_state", state_dbg, 1);
          check("start_overlap", in_flight, 0);
          if (exp_q.size() == 0) begin
            check("start_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("start_len", timer_length, e[LEN_W-1:0]);
            check("start_id", active_id, e[W-1:LEN_W]);
          end
          in_flight = 1'b1;
        end
        if (done != '0) begin
          check("done_onehot", 32'($onehot0(done)), 1);
          if (exp_done_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            d = exp_done_q.pop_front();
            check("done_vec", done, 32'd1 << d);
          end
          in_flight = 1'b0;
        end
      end else begin
        in_flight = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int n0, n1, nd, cyc;
    reset      = 1'b0;
    req        = '0;
    req_length = '0;
    cancel     = '0;
    man_exp    = 1'b0;
    auto_timer = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pending", pending, 0);
    check("rst_done", done, 0);
    check("rst_req_err", req_err, 0);
    check("rst_timer_start", timer_start, 0);
    check("rst_timer_length", timer_length, 0);
    check("rst_busy", busy, 0);
    check("rst_active_id", active_id, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single request with exact latencies
    do_reset();
    auto_timer = 1'b0;
    set_len(2, 5);
    req = 4'b0100;
    push_run(2, 5, 1);
    @(negedge clk);
    req = '0;
    check("single_pending", pending, 4'b0100);
    check("single_ts_early", timer_start, 0);
    @(negedge clk);
    check("single_ts", timer_start, 1);
    check("single_busy", busy, 1);
    check("single_active", active_id, 2);
    check("single_pending_clr", pending, 0);
    @(negedge clk);
    check("single_ts_one_cycle", timer_start, 0);
    repeat (3) @(negedge clk);
    man_exp = 1'b1;
    @(negedge clk);
    man_exp = 1'b0;
    check("single_done", done, 4'b0100);
    @(negedge clk);
    check("single_done_one_cycle", done, 0);
    check("single_busy_drop", busy, 0);
    check("single_starts_left", exp_q.size(), 0);

    // Contention: 0, 1, 3 requested together
    do_reset();
    auto_timer = 1'b1;
    set_len(0, 3); set_len(1, 7); set_len(3, 1);
    req = 4'b1011;
    push_run(0, 3, 1); push_run(1, 7, 1); push_run(3, 1, 1);
    @(negedge clk);
    req = '0;
    check("cont_pending", pending, 4'b1011);
    wait_idle("cont");

    // Zero length is forwarded and completes
    set_len(3, 0);
    req = 4'b1000;
    push_run(3, 0, 1);
    @(negedge clk);
    req = '0;
    wait_idle("zero");

    // Fairness: re-requests in DONE cycles give 0,1,0,1
    do_reset();
    auto_timer = 1'b1;
    set_len(0, 2); set_len(1, 4);
    req = 4'b0011;
    push_run(0, 2, 1); push_run(1, 4, 1); push_run(0, 6, 1); push_run(1, 1, 1);
    @(negedge clk);
    n0 = 0; n1 = 0; nd = 0; cyc = 0;
    while (nd < 4 && cyc < 600) begin
      req = '0;
      if (done[0]) begin
        nd++;
        if (n0 == 0) begin n0 = 1; req[0] = 1'b1; set_len(0, 6); end
      end
      if (done[1]) begin
        nd++;
        if (n1 == 0) begin n1 = 1; req[1] = 1'b1; set_len(1, 1); end
      end
      @(negedge clk);
      cyc++;
    end
    req = '0;
    check("fair_done_count", nd, 4);
    wait_idle("fair");

    // Reject: duplicate while pending, and request by the active owner
    do_reset();
    auto_timer = 1'b1;
    set_len(0, 5); set_len(1, 9);
    req = 4'b0011;
    push_run(0, 5, 1); push_run(1, 9, 1);
    @(negedge clk);
    req = 4'b0010;
    set_len(1, 2);
    check("rej_err_none", req_err, 0);
    @(negedge clk);
    req = '0;
    check("rej_err_pending", req_err, 4'b0010);
    @(negedge clk);
    check("rej_err_one_cycle", req_err, 0);
    check("rej_in_wait", state_dbg, 2);
    req = 4'b0001;
    set_len(0, 3);
    @(negedge clk);
    req = '0;
    check("rej_err_active", req_err, 4'b0001);
    wait_idle("rej");

    // Reset during WAIT abandons everything; later expiry ignored
    do_reset();
    auto_timer = 1'b0;
    set_len(2, 4); set_len(3, 1);
    req = 4'b1100;
    push_run(2, 4, 0);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check("rstmid_in_wait", state_dbg, 2);
    check("rstmid_pending", pending, 4'b1000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_pending_clr", pending, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_state", state_dbg, 0);
    reset   = 1'b1;
    man_exp = 1'b1;
    @(negedge clk);
    man_exp = 1'b0;
    check("rstmid_no_done", done, 0);
    repeat (3) @(negedge clk);
    check("rstmid_no_done_late", done, 0);
    check("rstmid_idle", state_dbg, 0);
    check("rstmid_starts_left", exp_q.size(), 0);

`ifdef TIMER_SCHED_CANCEL_EN
    // Cancel the active run in WAIT; stale expiry arrives in IDLE
    do_reset();
    auto_timer = 1'b1;
    set_len(0, 20); set_len(1, 2);
    req = 4'b0011;
    push_run(0, 20, 0); push_run(1, 2, 1);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check("cancel_in_wait", state_dbg, 2);
    cancel    = 4'b0001;
    in_flight = 1'b0;
    @(negedge clk);
    cancel = '0;
    check("cancel_idle", state_dbg, 0);
    check("cancel_no_done", done, 0);
    man_exp = 1'b1;
    @(negedge clk);
    man_exp = 1'b0;
    check("cancel_next_start", timer_start, 1);
    check("cancel_next_id", active_id, 1);
    wait_idle("cancel");
`endif

    check("final_starts_left", exp_q.size(), 0);
    check("final_dones_left", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
